lsu_byte_lane_ctrl: RTL and testbench

//  Load/store initiator that drives the byte-enable data memory port (WE, DataAdr, WriteData, web, ReadData).

---
 rtl/lsu_byte_lane_ctrl.sv | 164 ++++++++++++++++
 tb/tb_lsu_byte_lane_ctrl.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_byte_lane_ctrl.sv
// Byte-lane load/store initiator for a word-wide byte-enable data memory.
// Splits unaligned accesses across two words and merges/extends load data.
module lsu_byte_lane_ctrl #(
    parameter int MEM_WORDS = 64
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic        resp_err,
    output logic [31:0] resp_rdata,
    output logic        WE,
    output logic [31:0] DataAdr,
    output logic [31:0] WriteData,
    output logic [3:0]  web,
    input  logic [31:0] ReadData
);

    typedef enum logic [1:0] {
        IDLE,
        ACC0,
        ACC1,
        RESP
    } state_t;

    state_t state, state_nx;

    logic        we_q;
    logic        uns_q;
    logic        err_q;
    logic [1:0]  size_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rbuf;
    logic [31:0] adr_q;

    logic [2:0]  n_in;
    logic [2:0]  n_q;
    logic [32:0] last_byte;
    logic        bad_in;
    logic        split;
    logic        accept;
    logic        acc;
    logic [3:0]  lane_en;
    logic [3:0]  kidx [4];
    logic [31:0] ext;

    always_comb begin
        case (req_size)
            2'b00:   n_in = 3'd1;
            2'b01:   n_in = 3'd2;
            default: n_in = 3'd4;
        endcase
    end

    always_comb begin
        case (size_q)
            2'b00:   n_q = 3'd1;
            2'b01:   n_q = 3'd2;
            default: n_q = 3'd4;
        endcase
    end

    // 33-bit sum so addresses near 2^32 cannot wrap into range
    assign last_byte = {1'b0, req_addr} + {30'b0, n_in} - 33'd1;
    assign bad_in    = (req_size == 2'b11) ||
                       (last_byte >= 33'(4 * MEM_WORDS));

    assign split     = ({1'b0, addr_q[1:0]} + n_q) > 3'd4;
    assign req_ready = (state == IDLE);
    assign accept    = req_valid && req_ready;
    assign acc       = (state == ACC0) || (state == ACC1);

    // kidx[l] is the access byte index that lands on lane l this cycle
    always_comb begin
        for (int l = 0; l < 4; l++) begin
            kidx[l] = 4'(l) + ((state == ACC1) ? 4'd4 : 4'd0)
                      - {2'b00, addr_q[1:0]};
            lane_en[l] = acc && (kidx[l] < {1'b0, n_q});
        end
    end

    always_comb begin
        WE        = acc && we_q;
        web       = we_q ? lane_en : 4'b0000;
        WriteData = 32'h0;
        for (int l = 0; l < 4; l++) begin
            if (web[l])
                WriteData[8*l +: 8] = wdata_q[{kidx[l][1:0], 3'b000} +: 8];
        end
    end

    always_comb begin
        case (state)
            ACC0:    DataAdr = {addr_q[31:2], 2'b00};
            ACC1:    DataAdr = {addr_q[31:2] + 30'd1, 2'b00};
            default: DataAdr = adr_q;
        endcase
    end

    always_comb begin
        case (size_q)
            2'b00:   ext = {{24{~uns_q & rbuf[7]}}, rbuf[7:0]};
            2'b01:   ext = {{16{~uns_q & rbuf[15]}}, rbuf[15:0]};
            default: ext = rbuf;
        endcase
    end

    assign resp_valid = (state == RESP);
    assign resp_err   = resp_valid && err_q;
    assign resp_rdata = (resp_valid && !err_q && !we_q) ? ext : 32'h0;

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (accept) state_nx = bad_in ? RESP : ACC0;
            ACC0: state_nx = split ? ACC1 : RESP;
            ACC1: state_nx = RESP;
            RESP: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state <= IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            err_q   <= 1'b0;
            size_q  <= 2'b00;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            rbuf    <= 32'h0;
            adr_q   <= 32'h0;
        end else begin
            if (accept) begin
                we_q    <= req_we;
                uns_q   <= req_unsigned;
                err_q   <= bad_in;
                size_q  <= req_size;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                rbuf    <= 32'h0;
            end
            if (acc) begin
                adr_q <= DataAdr;
                for (int l = 0; l < 4; l++) begin
                    if (lane_en[l] && !we_q)
                        rbuf[{kidx[l][1:0], 3'b000} +: 8] <= ReadData[8*l +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_lsu_byte_lane_ctrl.sv
// Directed bench for lsu_byte_lane_ctrl against a 64-word byte-enable memory.
// Covers aligned, split, extension, range-error and mid-access reset cases.
module tb_lsu_byte_lane_ctrl;

    logic        CLK;
    logic        RST_N;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] resp_rdata;
    logic        WE;
    logic [31:0] DataAdr;
    logic [31:0] WriteData;
    logic [3:0]  web;
    logic [31:0] ReadData;

    int checks;
    int failures;

    logic [31:0] mem [64];
    logic        clr;
    logic        pl_en;
    logic [5:0]  pl_idx;
    logic [31:0] pl_val;

    lsu_byte_lane_ctrl #(.MEM_WORDS(64)) dut (
        .CLK          (CLK),
        .RST_N        (RST_N),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_err     (resp_err),
        .resp_rdata   (resp_rdata),
        .WE           (WE),
        .DataAdr      (DataAdr),
        .WriteData    (WriteData),
        .web          (web),
        .ReadData     (ReadData)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always_comb begin
        ReadData = 32'h0;
        if (DataAdr[31:8] == 24'h0)
            ReadData = mem[DataAdr[7:2]];
    end

    always @(posedge CLK) begin
        if (clr) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
        end else if (pl_en) begin
            mem[pl_idx] <= pl_val;
        end else if (WE && DataAdr[31:8] == 24'h0) begin
            for (int l = 0; l < 4; l++)
                if (web[l]) mem[DataAdr[7:2]][8*l +: 8] <= WriteData[8*l +: 8];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [5:0] idx, input logic [31:0] val);
        pl_en  = 1'b1;
        pl_idx = idx;
        pl_val = val;
        @(posedge CLK);
        #1 pl_en = 1'b0;
    endtask

    // Drives one request in an idle cycle; returns at the negedge of T+1
    task automatic issue(input logic we, input logic [1:0] sz,
                         input logic uns, input logic [31:0] a,
                         input logic [31:0] d);
        @(negedge CLK);
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = a;
        req_wdata    = d;
        chk("req_ready_idle", {31'b0, req_ready}, 32'd1);
        @(negedge CLK);
        req_valid = 1'b0;
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        RST_N        = 1'b0;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_size     = 2'b00;
        req_unsigned = 1'b0;
        req_addr     = 32'h0;
        req_wdata    = 32'h0;
        clr          = 1'b1;
        pl_en        = 1'b0;
        pl_idx       = 6'd0;
        pl_val       = 32'h0;

        #1;
        chk("rst_ready",      {31'b0, req_ready},  32'd1);
        chk("rst_we",         {31'b0, WE},         32'd0);
        chk("rst_web",        {28'b0, web},        32'd0);
        chk("rst_adr",        DataAdr,             32'd0);
        chk("rst_wdata",      WriteData,           32'd0);
        chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        chk("rst_resp_err",   {31'b0, resp_err},   32'd0);
        chk("rst_rdata",      resp_rdata,          32'd0);
        @(negedge CLK);
        @(negedge CLK);
        clr   = 1'b0;
        RST_N = 1'b1;

        // 1: aligned word store
        issue(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
        chk("t1_adr",   DataAdr,             32'h10);
        chk("t1_web",   {28'b0, web},        32'hF);
        chk("t1_wdata", WriteData,           32'hDEADBEEF);
        chk("t1_we",    {31'b0, WE},         32'd1);
        chk("t1_nresp", {31'b0, resp_valid}, 32'd0);
        @(negedge CLK);
        chk("t1_resp",  {31'b0, resp_valid}, 32'd1);
        chk("t1_err",   {31'b0, resp_err},   32'd0);
        chk("t1_rdata", resp_rdata,          32'd0);
        chk("t1_we_rs", {31'b0, WE},         32'd0);
        chk("t1_mem",   mem[4],              32'hDEADBEEF);

        // 2: byte/half loads with sign and zero extension
        preload(6'd4, 32'h80FF0000);
        issue(1'b0, 2'b00, 1'b0, 32'h13, 32'h0);
        chk("t2_adr",   DataAdr,             32'h10);
        chk("t2_we",    {31'b0, WE},         32'd0);
        chk("t2_web",   {28'b0, web},        32'd0);
        @(negedge CLK);
        chk("t2_resp",  {31'b0, resp_valid}, 32'd1);
        chk("t2_sb",    resp_rdata,          32'hFFFFFF80);
        issue(1'b0, 2'b00, 1'b1, 32'h13, 32'h0);
        @(negedge CLK);
        chk("t2_ub",    resp_rdata,          32'h00000080);
        issue(1'b0, 2'b01, 1'b0, 32'h12, 32'h0);
        @(negedge CLK);
        chk("t2_sh",    resp_rdata,          32'hFFFF80FF);
        issue(1'b0, 2'b01, 1'b1, 32'h10, 32'h0);
        @(negedge CLK);
        chk("t2_uh",    resp_rdata,          32'h00000000);

        // 3: split half store across 0x08/0x0C
        issue(1'b1, 2'b01, 1'b0, 32'h0B, 32'h00001234);
        chk("t3_adr0",  DataAdr,             32'h08);
        chk("t3_web0",  {28'b0, web},        32'h8);
        chk("t3_wd0",   WriteData,           32'h34000000);
        chk("t3_we0",   {31'b0, WE},         32'd1);
        @(negedge CLK);
        chk("t3_adr1",  DataAdr,             32'h0C);
        chk("t3_web1",  {28'b0, web},        32'h1);
        chk("t3_wd1",   WriteData,           32'h00000012);
        chk("t3_nresp", {31'b0, resp_valid}, 32'd0);
        @(negedge CLK);
        chk("t3_resp",  {31'b0, resp_valid}, 32'd1);
        chk("t3_we_rs", {31'b0, WE},         32'd0);
        chk("t3_hold",  DataAdr,             32'h0C);
        chk("t3_mem2",  mem[2],              32'h34000000);
        chk("t3_mem3",  mem[3],              32'h00000012);

        // 4: split word load
        preload(6'd3, 32'hAABBCCDD);
        preload(6'd4, 32'h11223344);
        issue(1'b0, 2'b10, 1'b0, 32'h0E, 32'h0);
        chk("t4_adr0",  DataAdr,             32'h0C);
        @(negedge CLK);
        chk("t4_adr1",  DataAdr,             32'h10);
        chk("t4_nresp", {31'b0, resp_valid}, 32'd0);
        @(negedge CLK);
        chk("t4_resp",  {31'b0, resp_valid}, 32'd1);
        chk("t4_rdata", resp_rdata,          32'h3344AABB);

        // 5: range and size errors, plus top-of-memory boundary
        issue(1'b1, 2'b10, 1'b0, 32'hFE, 32'h55667788);
        chk("t5a_resp", {31'b0, resp_valid}, 32'd1);
        chk("t5a_err",  {31'b0, resp_err},   32'd1);
        chk("t5a_rd",   resp_rdata,          32'd0);
        chk("t5a_we",   {31'b0, WE},         32'd0);
        issue(1'b0, 2'b11, 1'b0, 32'h00, 32'h0);
        chk("t5b_resp", {31'b0, resp_valid}, 32'd1);
        chk("t5b_err",  {31'b0, resp_err},   32'd1);
        chk("t5b_rd",   resp_rdata,          32'd0);
        chk("t5b_we",   {31'b0, WE},         32'd0);
        chk("t5_mem63", mem[63],             32'h0);
        preload(6'd63, 32'h8A020304);
        issue(1'b0, 2'b10, 1'b0, 32'hFC, 32'h0);
        @(negedge CLK);
        chk("t5c_err",  {31'b0, resp_err},   32'd0);
        chk("t5c_rd",   resp_rdata,          32'h8A020304);
        issue(1'b0, 2'b00, 1'b0, 32'hFF, 32'h0);
        @(negedge CLK);
        chk("t5d_rd",   resp_rdata,          32'hFFFFFF8A);
        issue(1'b0, 2'b01, 1'b0, 32'hFE, 32'h0);
        @(negedge CLK);
        chk("t5e_rd",   resp_rdata,          32'hFFFF8A02);
        issue(1'b0, 2'b01, 1'b0, 32'hFF, 32'h0);
        chk("t5f_err",  {31'b0, resp_err},   32'd1);
        chk("t5f_rd",   resp_rdata,          32'd0);

        // 6: reset during the second half of a split store
        issue(1'b1, 2'b01, 1'b0, 32'h0B, 32'h0000ABCD);
        @(negedge CLK);
        chk("t6_acc1",  {31'b0, WE},         32'd1);
        RST_N = 1'b0;
        #1;
        chk("t6_we",    {31'b0, WE},         32'd0);
        chk("t6_web",   {28'b0, web},        32'd0);
        chk("t6_ready", {31'b0, req_ready},  32'd1);
        chk("t6_adr",   DataAdr,             32'd0);
        chk("t6_resp",  {31'b0, resp_valid}, 32'd0);
        @(negedge CLK);
        chk("t6_resp2", {31'b0, resp_valid}, 32'd0);
        chk("t6_mem2",  mem[2],              32'hCD000000);
        chk("t6_mem3",  mem[3],              32'hAABBCCDD);
        RST_N = 1'b1;
        @(posedge CLK);
        #1;
        chk("t6_resp3", {31'b0, resp_valid}, 32'd0);
        issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        chk("t6_ladr",  DataAdr,             32'h10);
        @(negedge CLK);
        chk("t6_lresp", {31'b0, resp_valid}, 32'd1);
        chk("t6_lrd",   resp_rdata,          32'h11223344);

        @(negedge CLK);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
